// File: rtl/event_flag_scheduler.sv
// Sticky set/reset event flags with enable mask and a round-robin scheduler that
// offers one pending, eligible flag index at a time over a valid/ready handshake.
module event_flag_scheduler #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clrn,
    input  logic          clk,
    input  logic [N-1:0]  set,
    input  logic [N-1:0]  clr,
    input  logic          mask_wr,
    input  logic [N-1:0]  mask_in,
    output logic [N-1:0]  mask,
    output logic [N-1:0]  pend,
    output logic [N-1:0]  ovf,
    output logic          any_pend,
    output logic          req_valid,
    output logic [IW-1:0] req_idx,
    input  logic          req_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  pend_reg, pend_next;
    logic [N-1:0]  ovf_reg, ovf_next;
    logic [N-1:0]  mask_reg, mask_next;
    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0] req_idx_reg, req_idx_next;

    logic [N-1:0]  elig;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          accept;

    assign accept = (state_reg == OFFER) && req_ready;
    assign elig   = pend_reg & mask_reg;

    // Set has top priority over both the external clear and the acceptance clear.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_flag
            assign pend_next[gi] = set[gi] |
                                   (pend_reg[gi] & ~clr[gi] &
                                    ~(accept && (req_idx_reg == IW'(gi))));
            assign ovf_next[gi]  = (set[gi] & pend_reg[gi]) |
                                   (ovf_reg[gi] & ~(clr[gi] & ~set[gi]));
        end
    endgenerate

    assign mask_next = mask_wr ? mask_in : mask_reg;

    // First eligible index at or above rr_ptr, wrapping modulo N.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!sel_found && elig[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg   <= IDLE;
            pend_reg    <= '0;
            ovf_reg     <= '0;
            mask_reg    <= '1;
            rr_ptr_reg  <= '0;
            req_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pend_reg    <= pend_next;
            ovf_reg     <= ovf_next;
            mask_reg    <= mask_next;
            rr_ptr_reg  <= rr_ptr_next;
            req_idx_reg <= req_idx_next;
        end
    end

    // Once offered, the index stays committed until accepted, even if cleared or masked.
    always_comb begin
        state_next   = state_reg;
        req_idx_next = req_idx_reg;
        rr_ptr_next  = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next   = OFFER;
                    req_idx_next = sel_idx;
                end
            end
            OFFER: begin
                if (req_ready) begin
                    state_next  = IDLE;
                    rr_ptr_next = (req_idx_reg == IW'(N - 1)) ? '0 : req_idx_reg + IW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_valid = (state_reg == OFFER);
    end

    assign req_idx  = req_idx_reg;
    assign pend     = pend_reg;
    assign ovf      = ovf_reg;
    assign mask     = mask_reg;
    assign any_pend = |elig;

endmodule

// File: tb/tb_event_flag_scheduler.sv
// Self-checking bench for event_flag_scheduler: a vector table for round-robin order
// plus hand-written sequences, with a scoreboard of expected accepted indices.
module tb_event_flag_scheduler;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clrn;
    logic          clk;
    logic [N-1:0]  set;
    logic [N-1:0]  clr;
    logic          mask_wr;
    logic [N-1:0]  mask_in;
    logic [N-1:0]  mask;
    logic [N-1:0]  pend;
    logic [N-1:0]  ovf;
    logic          any_pend;
    logic          req_valid;
    logic [IW-1:0] req_idx;
    logic          req_ready;

    int errors = 0;
    int checks = 0;
    logic [IW-1:0] exp_q[$];

    event_flag_scheduler #(.N(N)) dut (
        .clrn      (clrn),
        .clk       (clk),
        .set       (set),
        .clr       (clr),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .mask      (mask),
        .pend      (pend),
        .ovf       (ovf),
        .any_pend  (any_pend),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] set;
        logic [7:0] pend;
        logic       valid;
        logic [2:0] idx;
        logic       any;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: an acceptance happens on the next rising edge when valid&ready here.
    always @(negedge clk) begin
        if (clrn && req_valid && req_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected: got idx %0d expected no acceptance", req_idx);
            end else begin
                logic [IW-1:0] e;
                e = exp_q.pop_front();
                if (req_idx !== e) begin
                    errors++;
                    $display("FAIL accept_idx: got %0d expected %0d", req_idx, e);
                end else begin
                    $display("ok   accept_idx: %0d", req_idx);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; set = '0; clr = '0; mask_wr = 1'b0; mask_in = '0; req_ready = 1'b0;
        tick(); tick();
        chk("rst_pend", pend, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_mask", mask, 8'hFF);
        chk("rst_valid", req_valid, 0);
        chk("rst_idx", req_idx, 0);
        chk("rst_any", any_pend, 0);
        clrn = 1'b1;
        tick();

        // Round-robin vectors with req_ready held high.
        tbl[0]  = '{8'h85, 8'h85, 1'b0, 3'd0, 1'b1};
        tbl[1]  = '{8'h00, 8'h85, 1'b1, 3'd0, 1'b1};
        tbl[2]  = '{8'h00, 8'h84, 1'b0, 3'd0, 1'b1};
        tbl[3]  = '{8'h00, 8'h84, 1'b1, 3'd2, 1'b1};
        tbl[4]  = '{8'h00, 8'h80, 1'b0, 3'd2, 1'b1};
        tbl[5]  = '{8'h00, 8'h80, 1'b1, 3'd7, 1'b1};
        tbl[6]  = '{8'h00, 8'h00, 1'b0, 3'd7, 1'b0};
        tbl[7]  = '{8'h04, 8'h04, 1'b0, 3'd7, 1'b1};
        tbl[8]  = '{8'h00, 8'h04, 1'b1, 3'd2, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[10] = '{8'h05, 8'h05, 1'b0, 3'd2, 1'b1};
        tbl[11] = '{8'h00, 8'h05, 1'b1, 3'd0, 1'b1};
        tbl[12] = '{8'h00, 8'h04, 1'b0, 3'd0, 1'b1};
        tbl[13] = '{8'h00, 8'h04, 1'b1, 3'd2, 1'b1};
        tbl[14] = '{8'h00, 8'h00, 1'b0, 3'd2, 1'b0};
        exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd7);
        exp_q.push_back(3'd2); exp_q.push_back(3'd0); exp_q.push_back(3'd2);
        req_ready = 1'b1;
        for (int r = 0; r < 15; r++) begin
            set = tbl[r].set;
            tick();
            chk($sformatf("rr%0d_pend", r), pend, tbl[r].pend);
            chk($sformatf("rr%0d_valid", r), req_valid, tbl[r].valid);
            chk($sformatf("rr%0d_idx", r), req_idx, tbl[r].idx);
            chk($sformatf("rr%0d_any", r), any_pend, tbl[r].any);
        end
        set = '0; req_ready = 1'b0;
        tick();

        // Backpressure: offer of 3 held stable for 10 cycles.
        set = 8'h08; tick();
        set = 8'h00; tick();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp%0d_valid", c), req_valid, 1);
            chk($sformatf("bp%0d_idx", c), req_idx, 3);
            tick();
        end
        exp_q.push_back(3'd3);
        req_ready = 1'b1; tick();
        req_ready = 1'b0;
        chk("bp_pend_cleared", pend, 0);
        chk("bp_valid_dropped", req_valid, 0);

        // Set beats the acceptance clear and raises overflow.
        set = 8'h10; tick();
        set = 8'h00; tick();
        chk("sw_offer_idx", req_idx, 4);
        set = 8'h10; req_ready = 1'b1; exp_q.push_back(3'd4); tick();
        set = 8'h00; req_ready = 1'b0;
        chk("sw_pend_kept", pend, 8'h10);
        chk("sw_ovf", ovf, 8'h10);
        tick();
        chk("sw_reoffer_valid", req_valid, 1);
        chk("sw_reoffer_idx", req_idx, 4);
        clr = 8'h10; tick();
        clr = 8'h00;
        chk("sw_clr_pend", pend, 0);
        chk("sw_clr_ovf", ovf, 0);
        chk("sw_committed", req_valid, 1);
        req_ready = 1'b1; exp_q.push_back(3'd4); tick();
        req_ready = 1'b0; tick();
        chk("sw_idle", req_valid, 0);

        // Mask gates eligibility only.
        mask_wr = 1'b1; mask_in = 8'hF0; set = 8'h11; tick();
        mask_wr = 1'b0; set = 8'h00;
        chk("mk_mask", mask, 8'hF0);
        chk("mk_pend", pend, 8'h11);
        tick();
        chk("mk_offer_valid", req_valid, 1);
        chk("mk_offer_idx", req_idx, 4);
        req_ready = 1'b1; exp_q.push_back(3'd4); tick();
        req_ready = 1'b0;
        chk("mk_pend0_kept", pend, 8'h01);
        chk("mk_any_zero", any_pend, 0);
        tick();
        chk("mk_no_offer", req_valid, 0);
        mask_wr = 1'b1; mask_in = 8'hFF; tick();
        mask_wr = 1'b0;
        chk("mk_any_one", any_pend, 1);
        tick();
        chk("mk_offer0_valid", req_valid, 1);
        chk("mk_offer0_idx", req_idx, 0);
        req_ready = 1'b1; exp_q.push_back(3'd0); tick();
        req_ready = 1'b0;
        chk("mk_done_pend", pend, 0);

        // Committed offer survives clear and mask-out.
        set = 8'h40; tick();
        set = 8'h00; tick();
        chk("co_offer_idx", req_idx, 6);
        clr = 8'h40; mask_wr = 1'b1; mask_in = 8'h00; tick();
        clr = 8'h00; mask_wr = 1'b0;
        chk("co_valid_kept", req_valid, 1);
        chk("co_idx_kept", req_idx, 6);
        chk("co_pend", pend, 0);
        chk("co_mask", mask, 8'h00);
        req_ready = 1'b1; exp_q.push_back(3'd6); tick();
        req_ready = 1'b0;
        chk("co_idle", req_valid, 0);
        tick(); tick();
        chk("co_no_more", req_valid, 0);
        chk("co_any", any_pend, 0);

        // Asynchronous reset in the middle of an offer.
        mask_wr = 1'b1; mask_in = 8'hE0; set = 8'h20; tick();
        mask_wr = 1'b0; set = 8'h00; tick();
        chk("ra_offer_valid", req_valid, 1);
        chk("ra_offer_idx", req_idx, 5);
        clrn = 1'b0; #1;
        chk("ra_valid", req_valid, 0);
        chk("ra_pend", pend, 0);
        chk("ra_mask", mask, 8'hFF);
        chk("ra_ovf", ovf, 0);
        tick();
        clrn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ra_post%0d_valid", c), req_valid, 0);
        end
        chk("ra_post_pend", pend, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
